// File: rtl/apb_regfile_pkg.sv
// Shared types and helpers for the apb_regfile APB register bank.
package apb_regfile_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int BUS_DATA_WIDTH = 32;
    localparam int STRB_WIDTH     = BUS_DATA_WIDTH / 8;
    localparam int CNT_W          = 4;

    // An access fails when it targets an unimplemented index, or when it is an
    // unprivileged write while protection checking is enabled.
    function automatic logic access_err(
        input int unsigned idx,
        input int unsigned count,
        input logic        wr,
        input logic        priv,
        input bit          prot_en
    );
        return (idx >= count) || (prot_en && wr && !priv);
    endfunction

endpackage

// File: rtl/apb_regfile_cell.sv
// One bus/hardware writable register: strobed bus bytes win, remaining bytes
// take hardware data when the hardware write is enabled, otherwise they hold.
module apb_regfile_cell
    import apb_regfile_pkg::*;
#(
    parameter int                    DATA_WIDTH  = BUS_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    bus_we,
    input  logic [DATA_WIDTH/8-1:0] bus_strb,
    input  logic [DATA_WIDTH-1:0]   bus_wdata,
    input  logic                    hw_we,
    input  logic [DATA_WIDTH-1:0]   hw_wdata,
    output logic [DATA_WIDTH-1:0]   q
);

    localparam int SW = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] d;

    always_comb begin
        d = q;
        for (int b = 0; b < SW; b++) begin
            if (bus_we && bus_strb[b]) begin
                d[b*8 +: 8] = bus_wdata[b*8 +: 8];
            end else if (hw_we) begin
                d[b*8 +: 8] = hw_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/apb_regfile.sv
// APB slave register bank with programmable wait states, byte strobes and
// hardware-side ports. Optional write protection check: APB_REGFILE_PROT_EN.
module apb_regfile
    import apb_regfile_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 4,
    parameter int                    DATA_WIDTH  = BUS_DATA_WIDTH,
    parameter int                    REG_COUNT   = 12,
    parameter int                    WAIT_STATES = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                            pclk,
    input  logic                            presetn,
    input  logic [ADDR_WIDTH-1:0]           paddr,
    input  logic [2:0]                      pprot,
    input  logic                            psel,
    input  logic                            penable,
    input  logic                            pwrite,
    input  logic [DATA_WIDTH-1:0]           pwdata,
    input  logic [DATA_WIDTH/8-1:0]         pstrb,
    output logic                            pready,
    output logic [DATA_WIDTH-1:0]           prdata,
    output logic                            pslverr,
    output logic [REG_COUNT*DATA_WIDTH-1:0] reg_q,
    output logic [REG_COUNT-1:0]            wr_pulse,
    input  logic [REG_COUNT-1:0]            hw_wr_en,
    input  logic [REG_COUNT*DATA_WIDTH-1:0] hw_wr_data
);

`ifdef APB_REGFILE_PROT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  access;
    logic                  commit;
    logic                  err;
    logic                  wr_ok;
    logic [REG_COUNT-1:0]  sel;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] reg_arr [REG_COUNT];
    logic                  unused_prot_hi;

    assign unused_prot_hi = |pprot[2:1];
    assign access = psel && penable;
    assign err    = access_err(32'(paddr), REG_COUNT, pwrite, pprot[0], PROT_EN);
    assign wr_ok  = commit && pwrite && !err && (|pstrb);

    // commit marks the edge that moves the FSM into RESP; data and response
    // registers are all updated on that same edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    cnt_d = CNT_W'(WAIT_STATES);
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                    end else begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (!access) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = RESP;
                    commit  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel     = '0;
        rd_data = '0;
        for (int n = 0; n < REG_COUNT; n++) begin
            if (paddr == ADDR_WIDTH'(n)) begin
                sel[n]  = 1'b1;
                rd_data = reg_arr[n];
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pready   <= 1'b0;
            pslverr  <= 1'b0;
            prdata   <= '0;
            wr_pulse <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pready   <= commit;
            pslverr  <= commit && err;
            wr_pulse <= wr_ok ? sel : '0;
            if (commit) begin
                if (err) begin
                    prdata <= '0;
                end else if (!pwrite) begin
                    prdata <= rd_data;
                end
            end
        end
    end

    for (genvar n = 0; n < REG_COUNT; n++) begin : g_cell
        apb_regfile_cell #(
            .DATA_WIDTH  (DATA_WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_cell (
            .pclk      (pclk),
            .presetn   (presetn),
            .bus_we    (wr_ok && sel[n]),
            .bus_strb  (pstrb),
            .bus_wdata (pwdata),
            .hw_we     (hw_wr_en[n]),
            .hw_wdata  (hw_wr_data[n*DATA_WIDTH +: DATA_WIDTH]),
            .q         (reg_arr[n])
        );
        assign reg_q[n*DATA_WIDTH +: DATA_WIDTH] = reg_arr[n];
    end

endmodule

// File: tb/tb_apb_regfile.sv
// Self-checking bench for apb_regfile: directed table, corner sequences and
// randomized transfers against a behavioural register model.
module tb_apb_regfile;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int RC = 12;
    localparam int WS = 2;
    localparam int SW = DW / 8;

`ifdef APB_REGFILE_PROT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    logic                 pclk = 1'b0;
    logic                 presetn;
    logic [AW-1:0]        paddr;
    logic [2:0]           pprot;
    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [DW-1:0]        pwdata;
    logic [SW-1:0]        pstrb;
    logic                 pready;
    logic [DW-1:0]        prdata;
    logic                 pslverr;
    logic [RC*DW-1:0]     reg_q;
    logic [RC-1:0]        wr_pulse;
    logic [RC-1:0]        hw_wr_en;
    logic [RC*DW-1:0]     hw_wr_data;

    apb_regfile #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .REG_COUNT   (RC),
        .WAIT_STATES (WS),
        .RESET_VALUE ('0)
    ) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .paddr      (paddr),
        .pprot      (pprot),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .pwdata     (pwdata),
        .pstrb      (pstrb),
        .pready     (pready),
        .prdata     (prdata),
        .pslverr    (pslverr),
        .reg_q      (reg_q),
        .wr_pulse   (wr_pulse),
        .hw_wr_en   (hw_wr_en),
        .hw_wr_data (hw_wr_data)
    );

    always #5 pclk = ~pclk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] model [RC];
    logic [DW-1:0] exp_prdata;

    typedef struct {
        logic [AW-1:0] a;
        logic          wr;
        logic [DW-1:0] wd;
        logic [SW-1:0] st;
        logic [DW-1:0] exp_rd;
        logic          exp_err;
        logic [RC-1:0] exp_pulse;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < RC; n++) model[n] = '0;
        exp_prdata = '0;
    endtask

    task automatic check_regs();
        for (int n = 0; n < RC; n++)
            chk($sformatf("reg_q[%0d]", n), reg_q[n*DW +: DW], model[n]);
    endtask

    // Entered and left at posedge+1; returns the access cycle in which pready
    // was seen (0 on timeout) and the response sampled in that cycle.
    task automatic xfer(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] wd,
                        input logic [SW-1:0] st, input logic [2:0] pr,
                        input int hw_at, input int hw_idx, input logic [DW-1:0] hw_d,
                        output int lat, output logic [DW-1:0] rd, output logic err,
                        output logic [RC-1:0] pulse);
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr;
        pwdata = wd; pstrb = st; pprot = pr;
        @(posedge pclk); #1;
        penable = 1'b1;
        lat = 0; rd = '0; err = 1'b0; pulse = '0;
        for (int k = 1; k <= 20; k++) begin
            hw_wr_en = '0;
            if (k == hw_at) begin
                hw_wr_en[hw_idx] = 1'b1;
                hw_wr_data[hw_idx*DW +: DW] = hw_d;
            end
            @(negedge pclk);
            if (pready) begin
                lat = k; rd = prdata; err = pslverr; pulse = wr_pulse;
                break;
            end
            @(posedge pclk); #1;
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; hw_wr_en = '0;
    endtask

    task automatic run(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] wd,
                       input logic [SW-1:0] st, input logic [2:0] pr,
                       input int hw_at, input int hw_idx, input logic [DW-1:0] hw_d,
                       output logic [DW-1:0] rd, output logic err, output logic [RC-1:0] pulse);
        int            lat;
        int            ai;
        int            cc;
        logic          e;
        logic [DW-1:0] erd;
        logic [RC-1:0] ep;
        ai = int'(a);
        cc = 1 + WS;
        e  = (ai >= RC) || (PROT_EN && wr && !pr[0]);
        if (hw_at >= 1 && hw_at < cc) model[hw_idx] = hw_d;
        if (e)        erd = '0;
        else if (!wr) erd = model[ai];
        else          erd = exp_prdata;
        ep = '0;
        if (!e && wr && st != '0) ep[ai] = 1'b1;
        xfer(a, wr, wd, st, pr, hw_at, hw_idx, hw_d, lat, rd, err, pulse);
        chk("latency", lat, 2 + WS);
        chk("pslverr", err, e);
        chk("prdata", rd, erd);
        chk("wr_pulse", pulse, ep);
        if (hw_at == cc) model[hw_idx] = hw_d;
        if (!e && wr)
            for (int b = 0; b < SW; b++)
                if (st[b]) model[ai][b*8 +: 8] = wd[b*8 +: 8];
        exp_prdata = erd;
        @(negedge pclk);
        chk("pready_one_cycle", pready, 1'b0);
        chk("wr_pulse_one_cycle", wr_pulse, '0);
        check_regs();
        @(posedge pclk); #1;
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic          err;
        logic [RC-1:0] pulse;

        presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = 3'b001;
        hw_wr_en = '0; hw_wr_data = '0;
        model_reset();
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("rst_pready", pready, 1'b0);
        chk("rst_pslverr", pslverr, 1'b0);
        chk("rst_prdata", prdata, '0);
        chk("rst_wr_pulse", wr_pulse, '0);
        check_regs();
        @(posedge pclk); #1;
        presetn = 1'b1;
        @(posedge pclk); #1;

        for (int i = 0; i < 12; i++)
            vecs[i] = '{AW'(i), 1'b0, '0, '0, '0, 1'b0, '0};
        vecs[12] = '{4'd3,  1'b1, 32'hDEADBEEF, 4'b0101, 32'h0,        1'b0, 12'h008};
        vecs[13] = '{4'd3,  1'b0, 32'h0,        4'b0000, 32'h00AD00EF, 1'b0, 12'h000};
        vecs[14] = '{4'd12, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b1, 12'h000};
        vecs[15] = '{4'd15, 1'b1, 32'hDEADBEEF, 4'b1111, 32'h0,        1'b1, 12'h000};
        vecs[16] = '{4'd4,  1'b1, 32'hFFFFFFFF, 4'b0000, 32'h0,        1'b0, 12'h000};
        vecs[17] = '{4'd3,  1'b0, 32'h0,        4'b0000, 32'h00AD00EF, 1'b0, 12'h000};
        vecs[18] = '{4'd3,  1'b1, 32'h12345678, 4'b1000, 32'h00AD00EF, 1'b0, 12'h008};
        vecs[19] = '{4'd3,  1'b0, 32'h0,        4'b0000, 32'h12AD00EF, 1'b0, 12'h000};

        for (int i = 0; i < 20; i++) begin
            run(vecs[i].a, vecs[i].wr, vecs[i].wd, vecs[i].st, 3'b001, 0, 0, '0, rd, err, pulse);
            chk($sformatf("tbl%0d_prdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("tbl%0d_pslverr", i), err, vecs[i].exp_err);
            chk($sformatf("tbl%0d_wr_pulse", i), pulse, vecs[i].exp_pulse);
            if (i == 12) chk("slice3_after_strobe_write", reg_q[3*DW +: DW], 32'h00AD00EF);
        end

        // Bus and hardware write to register 5 on the same edge.
        run(4'd5, 1'b1, 32'h11223344, 4'b0011, 3'b001, 1 + WS, 5, 32'hAABBCCDD, rd, err, pulse);
        chk("merge_slice5", reg_q[5*DW +: DW], 32'hAABB3344);

        // Stand-alone hardware write.
        hw_wr_en[9] = 1'b1;
        hw_wr_data[9*DW +: DW] = 32'h5A5A0001;
        @(posedge pclk); #1;
        hw_wr_en = '0;
        model[9] = 32'h5A5A0001;
        @(negedge pclk);
        chk("hw_only_slice9", reg_q[9*DW +: DW], 32'h5A5A0001);
        @(posedge pclk); #1;

        // Read racing a hardware write in its commit cycle returns the old value.
        run(4'd9, 1'b0, '0, '0, 3'b001, 1 + WS, 9, 32'h0BADF00D, rd, err, pulse);
        chk("race_read_old", rd, 32'h5A5A0001);
        chk("race_slice9_new", reg_q[9*DW +: DW], 32'h0BADF00D);

        // Abort: penable drops in the first WAIT cycle.
        psel = 1'b1; penable = 1'b0; paddr = 4'd7; pwrite = 1'b1;
        pwdata = 32'hCAFEF00D; pstrb = 4'hF; pprot = 3'b001;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        penable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge pclk);
            chk("abort_pready", pready, 1'b0);
            chk("abort_wr_pulse", wr_pulse, '0);
        end
        @(posedge pclk); #1;
        psel = 1'b0;
        check_regs();
        run(4'd7, 1'b0, '0, '0, 3'b001, 0, 0, '0, rd, err, pulse);

        // Reset asserted in the middle of a WAIT period.
        psel = 1'b1; penable = 1'b0; paddr = 4'd6; pwrite = 1'b1;
        pwdata = 32'hFFFFFFFF; pstrb = 4'hF; pprot = 3'b001;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        @(negedge pclk);
        presetn = 1'b0;
        #1;
        model_reset();
        chk("midrst_pready", pready, 1'b0);
        chk("midrst_prdata", prdata, '0);
        check_regs();
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        presetn = 1'b1;
        @(negedge pclk);
        chk("postrst_pready", pready, 1'b0);
        check_regs();
        @(posedge pclk); #1;
        run(4'd6, 1'b0, '0, '0, 3'b001, 0, 0, '0, rd, err, pulse);

`ifdef APB_REGFILE_PROT_EN
        run(4'd2, 1'b1, 32'h1, 4'hF, 3'b000, 0, 0, '0, rd, err, pulse);
        chk("prot_unpriv_err", err, 1'b1);
        chk("prot_unpriv_slice2", reg_q[2*DW +: DW], 32'h0);
        run(4'd2, 1'b1, 32'h1, 4'hF, 3'b001, 0, 0, '0, rd, err, pulse);
        chk("prot_priv_err", err, 1'b0);
        chk("prot_priv_slice2", reg_q[2*DW +: DW], 32'h1);
`endif

        for (int t = 0; t < 100; t++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge pclk); #1; end
            run(AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), DW'($urandom),
                SW'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                $urandom_range(0, 1 + WS), $urandom_range(0, RC - 1), DW'($urandom),
                rd, err, pulse);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_regfile.md
Name: apb_regfile

Overview:
Parametrised APB slave register file; successor to the fixed 2**ADDR_WIDTH byte-register block.
- Adds a non-power-of-two register count and a configurable number of wait states.
- Byte strobes at any width; PSLVERR on out-of-range addresses.
- Hardware-side parallel register outputs, write-notify pulses and hardware write ports for status capture.
- Sits behind the APB interconnect as a control/status bank for fabric logic.

Parameters:
- ADDR_WIDTH, 4, width of paddr; paddr is a register index, not a byte address.
- DATA_WIDTH, 32, register and bus width; must be a multiple of 8.
- REG_COUNT, 12, number of implemented registers; 1 <= REG_COUNT <= 2**ADDR_WIDTH.
- WAIT_STATES, 2, extra access-phase cycles inserted before pready; 0..15.
- RESET_VALUE, 0, DATA_WIDTH-bit reset value of every register.

Ports:
- pclk  in  1  clock.
- presetn  in  1  reset; asynchronous assert, active-low.
- paddr  in  ADDR_WIDTH  register index.
- pprot  in  3  protection; used only with APB_REGFILE_PROT_EN.
- psel  in  1  select.
- penable  in  1  access phase.
- pwrite  in  1  1 = write.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  DATA_WIDTH/8  byte strobes.
- pready  out  1  transfer complete (registered).
- prdata  out  DATA_WIDTH  read data (registered).
- pslverr  out  1  error response, valid with pready (registered).
- reg_q  out  REG_COUNT*DATA_WIDTH  all register contents; register n at bits [n*DATA_WIDTH +: DATA_WIDTH].
- wr_pulse  out  REG_COUNT  one-cycle pulse per register on a successful bus write.
- hw_wr_en  in  REG_COUNT  hardware write enable per register.
- hw_wr_data  in  REG_COUNT*DATA_WIDTH  hardware write data, same packing as reg_q.

Behaviour:
- Reset (presetn low, asynchronous):
  - pready=0, pslverr=0, prdata=0, wr_pulse=0.
  - All registers = RESET_VALUE; FSM = IDLE; wait counter = 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On psel&&penable: load counter with WAIT_STATES.
  - Go to WAIT if WAIT_STATES>0, else to RESP.
- WAIT:
  - Counter decrements each cycle; when it reaches 1, go to RESP.
  - If psel or penable drops, go to IDLE with no side effects (abort).
- RESP:
  - pready=1 for exactly one cycle, registered on the transition into RESP.
  - Commit happens on that same edge.
  - Next state is IDLE, so pready is never high two cycles in a row.
- Latency: pready is high in access-phase cycle 2+WAIT_STATES, counting the first penable cycle as 1.
- Error conditions: paddr >= REG_COUNT gives pslverr=1 with pready, no register change, prdata=0.
- Successful read: prdata = register[paddr], pslverr=0.
- Successful write:
  - Each byte with pstrb set takes pwdata; other bytes hold.
  - wr_pulse[paddr]=1 for the pready cycle if any strobe is set.
  - prdata holds its previous value.
- pstrb all zero on write: no change, no wr_pulse, pslverr=0.
- hw_wr_en[n]: register n takes hw_wr_data slice n on the next edge.
- Hardware write and bus write to the same register in the same cycle:
  - Strobed bytes take bus data.
  - Unstrobed bytes take hardware data.
- A hardware write to register paddr in the commit cycle of a read: prdata returns the pre-write value.
- reg_q is a direct register output with no extra latency.
- Reset mid-transfer: immediate return to IDLE, outputs at reset values, no partial write.

Optional Feature:
- Macro: APB_REGFILE_PROT_EN.
- Defined:
  - Writes with pprot[0]==0 (unprivileged) complete with pslverr=1, no change and no wr_pulse.
  - Reads are unaffected.
- Undefined: pprot is ignored entirely.

Decomposition:
- Shared package apb_regfile_pkg holds:
  - the FSM state enum (IDLE/WAIT/RESP);
  - localparam STRB_WIDTH = DATA_WIDTH/8;
  - counter width constant (4 bits);
  - an error-decode helper function.
- One natural sub-module, apb_regfile_cell, instantiated REG_COUNT times. It implements:
  - one register with strobe merge;
  - hardware-write merge;
  - reset value.
- The top module holds the FSM, counter, address decode and response registers.

Test Plan:
- Reset, then read index 0..11 -> prdata=0, pslverr=0 each; pready high exactly 3 access cycles after penable rises (WAIT_STATES=2).
- Write 0xDEADBEEF pstrb=4'b0101 to index 3 (was 0) -> reg_q slice 3 = 0x00AD00EF; wr_pulse[3] high one cycle coincident with pready.
- Read index 12 and write index 15 -> pslverr=1 with pready, prdata=0, no register or wr_pulse change.
- Same-cycle bus write 0x11223344 pstrb=4'b0011 and hw_wr_en[5] with 0xAABBCCDD -> register 5 = 0xAABB3344.
- Drop penable in the first WAIT cycle of a write, and separately assert presetn low mid-WAIT -> no register change, pready stays 0, FSM back to IDLE.
- With APB_REGFILE_PROT_EN: write 0x1 to index 2 with pprot=3'b000 -> pslverr=1, register unchanged; same write with pprot=3'b001 -> register 2 = 0x1.
